uart_rx_fifo: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo_mem.sv | 45 ++++
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - drain_state_t : states of the uart_rx_fifo drain FSM
//   - DEF_*         : default parameter values for uart_rx_fifo
//   - ASCII_*       : command characters recognised by ascii_decoder
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } drain_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_OUT_GAP    = 4;

    localparam logic [7:0] ASCII_R  = 8'h72;  // 'r'
    localparam logic [7:0] ASCII_L  = 8'h6C;  // 'l'
    localparam logic [7:0] ASCII_U  = 8'h75;  // 'u'
    localparam logic [7:0] ASCII_D  = 8'h64;  // 'd'
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for uart_rx_fifo: one write port, one read port with a
// registered output.
//   clk, rst              : clock, synchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data : write port, written on the rising edge
//   rd_en/rd_addr         : read request; rd_data updates on the edge with rd_en=1
//   rd_data               : registered read data, holds between reads, 0 after reset
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Contents are never reset so the array maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a read and a write to the same address on one edge
    // returns the old entry, which is what a full FIFO popping and pushing
    // simultaneously needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte buffer between uart_rx and ascii_decoder. Every rx_done byte is stored
// in a small FIFO and re-issued as a one-cycle out_done strobe, with at least
// OUT_GAP idle clocks between strobes.
//   clk, rst   : clock, synchronous active-high reset
//   rx_data    : received byte, valid with rx_done
//   rx_done    : one-cycle byte strobe from uart_rx
//   out_data   : byte to the decoder, held until the next out_done
//   out_done   : one-cycle strobe marking a new out_data
//   fifo_level : occupancy 0..DEPTH
//   overflow   : sticky, set when a byte is dropped on a full FIFO
//   ovf_clear  : one-cycle pulse clearing overflow (a same-edge drop wins)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int OUT_GAP    = DEF_OUT_GAP,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_done,
    output logic [LW-1:0]         fifo_level,
    output logic                  overflow,
    input  logic                  ovf_clear
);

    localparam int GW = $clog2(OUT_GAP + 1);

    drain_state_t    state_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic            out_done_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic            overflow_reg;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full = (level_reg == LW'(DEPTH));
    assign pop  = (state_reg == IDLE) && (level_reg != '0);
    // A pop on the same edge frees the slot being written, so a full FIFO
    // still accepts the byte in that case.
    assign push = rx_done && (!full || pop);
    assign drop = rx_done && full && !pop;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (rx_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr_reg),
        .rd_data (out_data)
    );

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop && !push) begin
                level_reg <= level_reg - 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clear) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Drain FSM: IDLE pops (read register loads out_data), EMIT raises
    // out_done for one cycle, GAP holds off for OUT_GAP cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gap_cnt_reg  <= '0;
            out_done_reg <= 1'b0;
        end else begin
            out_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        out_done_reg <= 1'b1;
                        state_reg    <= EMIT;
                    end
                end
                EMIT: begin
                    gap_cnt_reg <= GW'(OUT_GAP - 1);
                    state_reg   <= GAP;
                end
                GAP: begin
                    if (gap_cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_done   = out_done_reg;
    assign fifo_level = level_reg;
    assign overflow   = overflow_reg;

endmodule
